// File: rtl/isram_pipe.sv
// Read-only instruction-memory slave for the IFU: AR/R handshake, DEPTH-entry in-order
// response buffer, fixed or LFSR-randomised per-request latency.
module isram_pipe #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LAT_MIN   = 2,
   parameter int unsigned LAT_RAND  = 0,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        araddr_i,
   input  logic                     arvalid_i,
   output logic                     arready_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [1:0]               rresp_o,
   output logic                     rvalid_o,
   input  logic                     rready_i,
   output logic [$clog2(DEPTH):0]   outstanding_o
);

   localparam int unsigned PTR_W       = $clog2(DEPTH);
   localparam int unsigned CNT_W       = PTR_W + 1;
   localparam logic [7:0]  LAT_BASE_M1 = 8'(LAT_MIN - 1);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   // Physical-memory read hook; the body is a synthesizable ROM image standing in for
   // the simulator's memory (boot word at 0x8000_0000, error outside the 0x8xxx_xxxx region).
   function automatic logic [DATA_W-1:0] paddr_read(input logic [31:0] raddr,
                                                     output logic [7:0] rresp);
      rresp = (raddr[31:28] == 4'h8) ? 8'd0 : 8'd1;
      if (raddr == 32'h8000_0000)
         paddr_read = DATA_W'(32'h0000_0413);
      else
         paddr_read = DATA_W'({~raddr[15:0], raddr[15:0]});
   endfunction

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [1:0]        resp_q [DEPTH];
   logic [1:0]        resp_d [DEPTH];
   logic [7:0]        cnt_q  [DEPTH];
   logic [7:0]        cnt_d  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [7:0]        lfsr_q, lfsr_d;

   logic              push;
   logic              pop;
   logic              aligned;
   logic [31:0]       dpi_addr;
   logic [DATA_W-1:0] dpi_data;
   logic [7:0]        dpi_rsp;
   logic [7:0]        lat_m1;
   logic [DATA_W-1:0] new_data;
   logic [1:0]        new_resp;

   assign arready_o     = (count_q != CNT_W'(DEPTH));
   assign rvalid_o      = (count_q != '0) && (cnt_q[rd_ptr_q] == 8'd0);
   assign rdata_o       = data_q[rd_ptr_q];
   assign rresp_o       = resp_q[rd_ptr_q];
   assign outstanding_o = count_q;

   assign push     = arvalid_i && arready_o;
   assign pop      = rvalid_o && rready_i;
   assign dpi_addr = 32'(araddr_i);
   assign aligned  = (araddr_i[1:0] == 2'b00);

   // x^8+x^6+x^5+x^4+1, free-running
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Capture of the accepted request: memory is read only on an aligned accept.
   always_comb begin
      dpi_data = '0;
      dpi_rsp  = '0;
      new_data = '0;
      new_resp = RESP_SLVERR;
      lat_m1   = LAT_BASE_M1;
      if (LAT_RAND != 0)
         lat_m1 = LAT_BASE_M1 + {5'd0, lfsr_q[2:0]};
      if (push && aligned) begin
         dpi_data = paddr_read(dpi_addr, dpi_rsp);
         new_data = dpi_data;
         new_resp = (dpi_rsp != 8'd0) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // Buffer next state; countdowns of waiting entries saturate at zero behind the head.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_d   = data_q;
      resp_d   = resp_q;
      for (int i = 0; i < DEPTH; i++)
         cnt_d[i] = (cnt_q[i] != 8'd0) ? cnt_q[i] - 8'd1 : 8'd0;
      if (push) begin
         data_d[wr_ptr_q] = new_data;
         resp_d[wr_ptr_q] = new_resp;
         cnt_d[wr_ptr_q]  = lat_m1;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            resp_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         lfsr_q   <= LFSR_SEED;
      end else begin
         data_q   <= data_d;
         resp_q   <= resp_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         lfsr_q   <= lfsr_d;
      end
   end

endmodule
